// File: rtl/ram_access_ctrl.sv
// Load/store request controller in front of the byte/word RAM.
// Bounds-checks requests, splits halfword stores into two byte writes, extends loads.
module ram_access_ctrl #(
    parameter int unsigned MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        ram_write_enable,
    output logic        ram_is32bitWrite,
    output logic [31:0] ram_addr,
    output logic [7:0]  ram_bus_to_mem,
    output logic [31:0] ram_bus_to_mem_32,
    input  logic [7:0]  ram_bus_from_mem,
    input  logic [31:0] ram_bus_from_mem_32
);

    typedef enum logic [1:0] {IDLE, HALF2, RESP} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [7:0]  byte_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic [2:0]  nbytes;
    logic [32:0] end_addr;
    logic        bad;
    logic        accept;
    logic        store_ok;
    logic [31:0] load_ext;

    always_comb begin
        nbytes = 3'd0;
        case (req_size)
            2'd0:    nbytes = 3'd1;
            2'd1:    nbytes = 3'd2;
            2'd2:    nbytes = 3'd4;
            default: nbytes = 3'd0;
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range
    assign end_addr = {1'b0, req_addr} + {30'b0, nbytes};
    assign bad      = (req_size == 2'd3) || (end_addr > 33'(MEM_BYTES));

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign store_ok  = accept && req_write && !bad;

    assign ram_write_enable  = store_ok || (state_q == HALF2);
    assign ram_is32bitWrite  = store_ok && (req_size == 2'd2);
    assign ram_addr          = accept ? req_addr : addr_q;
    assign ram_bus_to_mem    = accept ? req_wdata[7:0] : byte_q;
    assign ram_bus_to_mem_32 = accept ? req_wdata : '0;

    always_comb begin
        load_ext = '0;
        case (req_size)
            2'd0:    load_ext = {{24{req_signed & ram_bus_from_mem[7]}}, ram_bus_from_mem};
            2'd1:    load_ext = {{16{req_signed & ram_bus_from_mem_32[15]}}, ram_bus_from_mem_32[15:0]};
            2'd2:    load_ext = ram_bus_from_mem_32;
            default: load_ext = '0;
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_error = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            byte_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        err_q   <= bad;
                        rdata_q <= '0;
                        state_q <= RESP;
                        if (!bad && !req_write) begin
                            rdata_q <= load_ext;
                        end
                        // Halfword store: low byte lands now, high byte on the HALF2 edge
                        if (!bad && req_write && (req_size == 2'd1)) begin
                            addr_q  <= req_addr + 32'd1;
                            byte_q  <= req_wdata[15:8];
                            state_q <= HALF2;
                        end
                    end
                end
                HALF2: state_q <= RESP;
                RESP: begin
                    if (rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed self-checking bench for ram_access_ctrl with a 32-byte RAM model.
module tb_ram_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_error;
    logic [31:0] rsp_rdata;
    logic        ram_write_enable, ram_is32bitWrite;
    logic [31:0] ram_addr, ram_bus_to_mem_32, ram_bus_from_mem_32;
    logic [7:0]  ram_bus_to_mem, ram_bus_from_mem;

    int checks   = 0;
    int failures = 0;
    int we_count = 0;
    int we_base;

    logic [7:0] mem [0:31] = '{default: 8'h00};

    always #5 clk = ~clk;

    ram_access_ctrl #(.MEM_BYTES(32)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .req_valid           (req_valid),
        .req_ready           (req_ready),
        .req_write           (req_write),
        .req_size            (req_size),
        .req_signed          (req_signed),
        .req_addr            (req_addr),
        .req_wdata           (req_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_ready           (rsp_ready),
        .rsp_rdata           (rsp_rdata),
        .rsp_error           (rsp_error),
        .ram_write_enable    (ram_write_enable),
        .ram_is32bitWrite    (ram_is32bitWrite),
        .ram_addr            (ram_addr),
        .ram_bus_to_mem      (ram_bus_to_mem),
        .ram_bus_to_mem_32   (ram_bus_to_mem_32),
        .ram_bus_from_mem    (ram_bus_from_mem),
        .ram_bus_from_mem_32 (ram_bus_from_mem_32)
    );

    // RAM model: combinational reads, writes on the rising edge
    always_comb begin
        logic [4:0] a;
        a = ram_addr[4:0];
        ram_bus_from_mem    = mem[a];
        ram_bus_from_mem_32 = {mem[a + 5'd3], mem[a + 5'd2], mem[a + 5'd1], mem[a]};
    end

    always @(posedge clk) begin
        if (ram_write_enable) begin
            we_count <= we_count + 1;
            if (ram_is32bitWrite) begin
                mem[ram_addr[4:0]]        <= ram_bus_to_mem_32[7:0];
                mem[ram_addr[4:0] + 5'd1] <= ram_bus_to_mem_32[15:8];
                mem[ram_addr[4:0] + 5'd2] <= ram_bus_to_mem_32[23:16];
                mem[ram_addr[4:0] + 5'd3] <= ram_bus_to_mem_32[31:24];
            end else begin
                mem[ram_addr[4:0]] <= ram_bus_to_mem;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
    endtask

    // Returns at the falling edge right after the accepting rising edge
    task automatic wait_accept(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Expects rsp_ready=1; consumes the response and returns at the next falling edge
    task automatic wait_rsp(input string tag, input int exp_wait,
                            input logic [31:0] exp_data, input logic exp_err);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, exp_wait);
        chk({tag, "_data"}, rsp_rdata, exp_data);
        chk({tag, "_err"}, {31'b0, rsp_error}, {31'b0, exp_err});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d, input int exp_wait,
                      input logic [31:0] exp_data, input logic exp_err);
        drive(w, sz, sg, a, d);
        wait_accept(tag);
        wait_rsp(tag, exp_wait, exp_data, exp_err);
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344);

        // Request held through reset
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_we", {31'b0, ram_write_enable}, 32'd0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rel_we", {31'b0, ram_write_enable}, 32'd1);
        chk("rel_is32", {31'b0, ram_is32bitWrite}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rel_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rel_mem0", {24'b0, mem[0]}, 32'h44);
        chk("rel_mem3", {24'b0, mem[3]}, 32'h11);
        @(posedge clk);
        @(negedge clk);

        // Word store then loads of various sizes
        op("clr0c", 1'b1, 2'd0, 1'b0, 32'h0C, 32'h00, 0, 32'h0, 1'b0);
        op("st_w08", 1'b1, 2'd2, 1'b0, 32'h08, 32'hAABBCCDD, 0, 32'h0, 1'b0);
        op("ld_sb09", 1'b0, 2'd0, 1'b1, 32'h09, 32'h0, 0, 32'hFFFFFFCC, 1'b0);
        op("ld_ub09", 1'b0, 2'd0, 1'b0, 32'h09, 32'h0, 0, 32'h000000CC, 1'b0);
        op("ld_uh0a", 1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, 0, 32'h0000AABB, 1'b0);
        op("ld_sh08", 1'b0, 2'd1, 1'b1, 32'h08, 32'h0, 0, 32'hFFFFCCDD, 1'b0);
        op("ld_uw09", 1'b0, 2'd2, 1'b0, 32'h09, 32'h0, 0, 32'h00AABBCC, 1'b0);

        // Halfword store split into two byte writes
        we_base = we_count;
        drive(1'b1, 2'd1, 1'b0, 32'h10, 32'h00001234);
        #1;
        chk("hs_a_we", {31'b0, ram_write_enable}, 32'd1);
        chk("hs_a_addr", ram_addr, 32'h10);
        chk("hs_a_byte", {24'b0, ram_bus_to_mem}, 32'h34);
        wait_accept("hs");
        chk("hs_b_we", {31'b0, ram_write_enable}, 32'd1);
        chk("hs_b_is32", {31'b0, ram_is32bitWrite}, 32'd0);
        chk("hs_b_addr", ram_addr, 32'h11);
        chk("hs_b_byte", {24'b0, ram_bus_to_mem}, 32'h12);
        chk("hs_b_valid", {31'b0, rsp_valid}, 32'd0);
        wait_rsp("hs", 1, 32'h0, 1'b0);
        chk("hs_we_cycles", we_count - we_base, 2);
        op("ld_uh10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 0, 32'h00001234, 1'b0);

        // Range limits and malformed sizes
        we_base = we_count;
        op("e_hs1f", 1'b1, 2'd1, 1'b0, 32'h1F, 32'hFFFF, 0, 32'h0, 1'b1);
        op("e_lwfe", 1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'h0, 0, 32'h0, 1'b1);
        op("e_sz3", 1'b1, 2'd3, 1'b0, 32'h00, 32'hDEADBEEF, 0, 32'h0, 1'b1);
        op("e_sw1d", 1'b1, 2'd2, 1'b0, 32'h1D, 32'hCAFEF00D, 0, 32'h0, 1'b1);
        chk("err_no_write", we_count - we_base, 0);
        chk("err_mem00", {24'b0, mem[0]}, 32'h44);
        chk("err_mem1f", {24'b0, mem[31]}, 32'h00);
        op("ok_sw1c", 1'b1, 2'd2, 1'b0, 32'h1C, 32'h01020304, 0, 32'h0, 1'b0);
        op("ok_lb1f", 1'b0, 2'd0, 1'b0, 32'h1F, 32'h0, 0, 32'h00000001, 1'b0);

        // Response back-pressure
        rsp_ready = 1'b0;
        drive(1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
        wait_accept("bp");
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'b0, rsp_valid}, 32'd1);
            chk("bp_data", rsp_rdata, 32'hAABBCCDD);
            chk("bp_err", {31'b0, rsp_error}, 32'd0);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {31'b0, req_ready}, 32'd1);
        chk("bp_idle_valid", {31'b0, rsp_valid}, 32'd0);

        // Reset during HALF2
        op("st_b05", 1'b1, 2'd0, 1'b0, 32'h05, 32'h5A, 0, 32'h0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 32'h04, 32'h0000BEEF);
        wait_accept("hr");
        chk("hr_half2_addr", ram_addr, 32'h05);
        rst_n = 1'b0;
        #1;
        chk("hr_we", {31'b0, ram_write_enable}, 32'd0);
        chk("hr_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("hr_mem04", {24'b0, mem[4]}, 32'hEF);
        chk("hr_mem05", {24'b0, mem[5]}, 32'h5A);
        chk("hr_no_rsp", {31'b0, rsp_valid}, 32'd0);
        chk("hr_ready", {31'b0, req_ready}, 32'd1);

        // Reset during RESP drops the response asynchronously
        drive(1'b0, 2'd0, 1'b0, 32'h04, 32'h0);
        wait_accept("rr");
        chk("rr_valid_before", {31'b0, rsp_valid}, 32'd1);
        chk("rr_data_before", rsp_rdata, 32'h000000EF);
        rst_n = 1'b0;
        #1;
        chk("rr_valid_after", {31'b0, rsp_valid}, 32'd0);
        chk("rr_data_after", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rr_ready", {31'b0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
